// File: rtl/papilio_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding and
// sizing helper used for source-ID widths.
package papilio_arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT
  } arb_state_e;

  // A one-bit ID is still needed when there are only two requesters.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: finds the first requesting index strictly after
// last_grant, wrapping around to last_grant itself as the lowest priority.
module rr_pick
  import papilio_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last_grant,
  output logic                any_req,
  output logic [ID_WIDTH-1:0] winner
);

  // Two descending passes: the wrapped range first, so the range above
  // last_grant overrides it and the lowest index there wins.
  always_comb begin
    any_req = |req;
    winner  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (ID_WIDTH'(i) <= last_grant)) begin
        winner = ID_WIDTH'(i);
      end else begin
        winner = winner;
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (ID_WIDTH'(i) > last_grant)) begin
        winner = ID_WIDTH'(i);
      end else begin
        winner = winner;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter sharing one fifo_sync write port between
// NUM_REQ ready/valid producers; tags each beat with its source ID.
module fifo_wr_arbiter
  import papilio_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16,
  parameter int ID_WIDTH   = clog2_min1(NUM_REQ),
  parameter int CNT_WIDTH  = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          fifo_wr_valid,
  input  logic                          fifo_wr_ready,
  output logic [ID_WIDTH-1:0]           fifo_wr_id,
  output logic                          busy
);

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(MAX_BURST - 1);

  arb_state_e            state_r, state_s;
  logic [ID_WIDTH-1:0]   grant_id_r, grant_id_s;
  logic [ID_WIDTH-1:0]   last_grant_r, last_grant_s;
  logic [CNT_WIDTH-1:0]  beat_cnt_r, beat_cnt_s;
  logic                  any_req_s;
  logic [ID_WIDTH-1:0]   winner_s;
  logic                  sel_valid_s;
  logic                  sel_last_s;
  logic [DATA_WIDTH-1:0] sel_data_s;

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .any_req    (any_req_s),
    .winner     (winner_s)
  );

  assign busy = (state_r == GRANT);

  // AND-OR mux of the granted requester's valid/last/data
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_valid_s = sel_valid_s | ((ID_WIDTH'(i) == grant_id_r) & req_valid[i]);
      sel_last_s  = sel_last_s  | ((ID_WIDTH'(i) == grant_id_r) & req_last[i]);
      sel_data_s  = sel_data_s  |
                    ({DATA_WIDTH{ID_WIDTH'(i) == grant_id_r}} & req_data[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Next-state logic and the combinational write-port pass-through
  always_comb begin
    state_s       = state_r;
    grant_id_s    = grant_id_r;
    last_grant_s  = last_grant_r;
    beat_cnt_s    = beat_cnt_r;
    fifo_wr_valid = 1'b0;
    fifo_wr_data  = '0;
    fifo_wr_id    = '0;
    req_ready     = '0;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          grant_id_s   = winner_s;
          last_grant_s = winner_s;
          beat_cnt_s   = '0;
          state_s      = GRANT;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        // valid never looks at fifo_wr_ready, so no loop through the FIFO
        fifo_wr_valid = sel_valid_s;
        fifo_wr_data  = sel_data_s;
        fifo_wr_id    = grant_id_r;
        for (int i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = (ID_WIDTH'(i) == grant_id_r) & fifo_wr_ready;
        end
        if (sel_valid_s && fifo_wr_ready) begin
          beat_cnt_s = beat_cnt_r + CNT_WIDTH'(1);
          if (sel_last_s || (beat_cnt_r == LAST_BEAT)) begin
            state_s = IDLE;
          end else begin
            state_s = GRANT;
          end
        end else begin
          beat_cnt_s = beat_cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM, grant and burst-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      grant_id_r   <= '0;
      last_grant_r <= ID_WIDTH'(NUM_REQ - 1);
      beat_cnt_r   <= '0;
    end else begin
      state_r      <= state_s;
      grant_id_r   <= grant_id_s;
      last_grant_r <= last_grant_s;
      beat_cnt_r   <= beat_cnt_s;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter (MAX_BURST=4) plus standalone rr_pick
// vectors; expected FIFO contents are queued by each directed test.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int IW = 2;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         gap;
  } beat_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_valid, req_last, req_ready;
  logic [DW-1:0]    fifo_wr_data;
  logic             fifo_wr_valid, fifo_wr_ready;
  logic [IW-1:0]    fifo_wr_id;
  logic             busy;

  logic [NR-1:0]    pick_req;
  logic [IW-1:0]    pick_last, pick_win;
  logic             pick_any;

  beat_t            prod_q [NR][$];
  exp_t             exp_q[$];
  int               xfer_cyc[$];
  logic [NR-1:0]    hs;
  logic             rdy_want;
  int               cyc;
  int               errors;
  int               checks;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .fifo_wr_data  (fifo_wr_data),
    .fifo_wr_valid (fifo_wr_valid),
    .fifo_wr_ready (fifo_wr_ready),
    .fifo_wr_id    (fifo_wr_id),
    .busy          (busy)
  );

  rr_pick #(.NUM_REQ(NR)) u_pick (
    .req        (pick_req),
    .last_grant (pick_last),
    .any_req    (pick_any),
    .winner     (pick_win)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard
  always begin
    @(negedge clk);
    #2;
    if (rst_n === 1'b1 && fifo_wr_valid === 1'b1 && fifo_wr_ready === 1'b1) begin
      xfer_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_beat", {24'd0, fifo_wr_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_data", {24'd0, fifo_wr_data}, {24'd0, e.data});
        chk("sb_id", {30'd0, fifo_wr_id}, {30'd0, e.id});
      end
    end
  end

  task automatic push(input int src, input logic [7:0] d, input logic l, input int gap);
    beat_t b;
    b.data = d;
    b.last = l;
    b.gap  = gap;
    prod_q[src].push_back(b);
  endtask

  task automatic expect_beat(input logic [IW-1:0] id, input logic [DW-1:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  function automatic logic pending();
    logic p;
    p = 1'b0;
    for (int i = 0; i < NR; i++) p = p | (prod_q[i].size() != 0);
    return p;
  endfunction

  // One clock: retire last cycle's handshakes, drive new inputs at negedge
  task automatic step();
    @(posedge clk);
    cyc++;
    for (int i = 0; i < NR; i++) begin
      if (hs[i] && prod_q[i].size() != 0) void'(prod_q[i].pop_front());
    end
    @(negedge clk);
    fifo_wr_ready = rdy_want;
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = 1'b0;
      req_last[i]  = 1'b0;
      req_data[i*DW +: DW] = '0;
      if (prod_q[i].size() != 0) begin
        if (prod_q[i][0].gap > 0) begin
          prod_q[i][0].gap = prod_q[i][0].gap - 1;
        end else begin
          req_valid[i] = 1'b1;
          req_last[i]  = prod_q[i][0].last;
          req_data[i*DW +: DW] = prod_q[i][0].data;
        end
      end
    end
    #1;
    hs = req_valid & req_ready;
  endtask

  task automatic drain(input int max_steps);
    int n;
    n = 0;
    while ((pending() || exp_q.size() != 0) && n < max_steps) begin
      step();
      n++;
    end
    chk("drain_timeout", {31'd0, n < max_steps}, 32'd1);
  endtask

  task automatic do_reset();
    for (int i = 0; i < NR; i++) prod_q[i].delete();
    hs    = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]    v_req  [8] = '{4'b1111, 4'b1111, 4'b1001, 4'b0001, 4'b0110, 4'b1000, 4'b0101, 4'b0000};
    logic [IW-1:0] v_last [8] = '{2'd3, 2'd0, 2'd0, 2'd0, 2'd2, 2'd3, 2'd1, 2'd1};
    logic [IW-1:0] v_win  [8] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3, 2'd2, 2'd0};
    errors = 0;
    checks = 0;
    cyc = 0;
    hs = '0;
    rst_n = 1'b0;
    rdy_want = 1'b1;
    fifo_wr_ready = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    pick_req = '0;
    pick_last = '0;

    // Standalone round-robin selector
    for (int k = 0; k < 8; k++) begin
      pick_req  = v_req[k];
      pick_last = v_last[k];
      #1;
      chk("pick_any", {31'd0, pick_any}, {31'd0, v_req[k] != 4'b0000});
      if (v_req[k] != 4'b0000) chk("pick_winner", {30'd0, pick_win}, {30'd0, v_win[k]});
    end

    // Reset values
    @(negedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, fifo_wr_valid}, 32'd0);
    chk("rst_id", {30'd0, fifo_wr_id}, 32'd0);
    chk("rst_data", {24'd0, fifo_wr_data}, 32'd0);
    chk("rst_beat_cnt", {29'd0, dut.beat_cnt_r}, 32'd0);
    rst_n = 1'b1;

    // T1: single source, requester 2, three beats
    push(2, 8'hA1, 1'b0, 0);
    push(2, 8'hA2, 1'b0, 0);
    push(2, 8'hA3, 1'b1, 0);
    expect_beat(2'd2, 8'hA1);
    expect_beat(2'd2, 8'hA2);
    expect_beat(2'd2, 8'hA3);
    step();
    chk("t1_ready_arb_cycle", {28'd0, req_ready}, 32'd0);
    step();
    chk("t1_ready_granted", {28'd0, req_ready}, 32'h4);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    step();
    step();
    step();
    chk("t1_busy_released", {31'd0, busy}, 32'd0);
    chk("t1_sb_empty", exp_q.size(), 32'd0);

    // T2: all four sources, 1-beat packets, order 0,1,2,3,0 with 1 idle gap
    do_reset();
    xfer_cyc.delete();
    for (int s = 0; s < NR; s++) begin
      push(s, 8'hC0 + 8'(s), 1'b1, 0);
      expect_beat(IW'(s), 8'hC0 + 8'(s));
    end
    push(0, 8'hC4, 1'b1, 0);
    expect_beat(2'd0, 8'hC4);
    drain(40);
    chk("t2_xfer_count", xfer_cyc.size(), 32'd5);
    if (xfer_cyc.size() == 5) begin
      for (int k = 1; k < 5; k++) chk("t2_grant_gap", xfer_cyc[k] - xfer_cyc[k-1], 32'd2);
    end

    // T3: forced release after MAX_BURST beats, source 0 slots in between
    do_reset();
    for (int k = 0; k < 10; k++) push(1, 8'h10 + 8'(k), 1'b0, 0);
    push(0, 8'hE0, 1'b0, 1);
    push(0, 8'hE1, 1'b1, 0);
    for (int k = 0; k < 4; k++) expect_beat(2'd1, 8'h10 + 8'(k));
    expect_beat(2'd0, 8'hE0);
    expect_beat(2'd0, 8'hE1);
    for (int k = 4; k < 10; k++) expect_beat(2'd1, 8'h10 + 8'(k));
    drain(60);
    chk("t3_lock_held", {31'd0, busy}, 32'd1);
    chk("t3_lock_no_valid", {31'd0, fifo_wr_valid}, 32'd0);

    // T4: backpressure for 5 cycles mid-burst
    do_reset();
    push(2, 8'hB1, 1'b0, 0);
    push(2, 8'hB2, 1'b0, 0);
    push(2, 8'hB3, 1'b1, 0);
    expect_beat(2'd2, 8'hB1);
    expect_beat(2'd2, 8'hB2);
    expect_beat(2'd2, 8'hB3);
    step();
    step();
    rdy_want = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_stall_data", {24'd0, fifo_wr_data}, 32'hB2);
      chk("t4_stall_id", {30'd0, fifo_wr_id}, 32'd2);
      chk("t4_stall_valid", {31'd0, fifo_wr_valid}, 32'd1);
      chk("t4_stall_beat_cnt", {29'd0, dut.beat_cnt_r}, 32'd1);
    end
    rdy_want = 1'b1;
    drain(20);

    // T5: granted source 1 stalls 3 cycles mid-packet, source 3 waits
    do_reset();
    push(1, 8'hF0, 1'b0, 0);
    push(1, 8'hF1, 1'b0, 3);
    push(1, 8'hF2, 1'b1, 0);
    push(3, 8'h30, 1'b1, 0);
    expect_beat(2'd1, 8'hF0);
    expect_beat(2'd1, 8'hF1);
    expect_beat(2'd1, 8'hF2);
    expect_beat(2'd3, 8'h30);
    step();
    step();
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t5_ready3_locked", {31'd0, req_ready[3]}, 32'd0);
    end
    step();
    chk("t5_ready3_granted", {28'd0, req_ready}, 32'h8);
    drain(20);

    // T6: reset asserted mid-burst, then requester 0 wins first
    do_reset();
    push(1, 8'h50, 1'b0, 0);
    push(1, 8'h51, 1'b0, 0);
    push(1, 8'h52, 1'b1, 0);
    expect_beat(2'd1, 8'h50);
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    hs = req_valid & req_ready;
    chk("t6_rst_ready", {28'd0, req_ready}, 32'd0);
    chk("t6_rst_valid", {31'd0, fifo_wr_valid}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < NR; i++) prod_q[i].delete();
    step();
    step();
    rst_n = 1'b1;
    chk("t6_sb_empty", exp_q.size(), 32'd0);
    push(0, 8'h60, 1'b1, 0);
    push(2, 8'h62, 1'b1, 0);
    expect_beat(2'd0, 8'h60);
    expect_beat(2'd2, 8'h62);
    drain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
